wave_rom_scheduler: RTL

WAVE_ROM_SCHEDULER -- requirements
Module: wave_rom_scheduler

---
 rtl/note_pkg.sv | 20 ++
 rtl/wave_rom_scheduler_if.sv | 31 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/wave_rom_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared defaults, midpoint sample constant and pipeline stage encoding
package note_pkg;

  localparam int DEF_NUM_VOICES = 3;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DATA_W     = 8;

  // Silent (centre) value of an unsigned sample: MSB set, rest clear.
  localparam logic [DEF_DATA_W-1:0] SAMPLE_MID = {1'b1, {(DEF_DATA_W-1){1'b0}}};

  // Occupancy of the two-stage read pipeline; issue and capture overlap
  // when grants are back to back.
  typedef enum logic [1:0] {
    PS_IDLE    = 2'b00,
    PS_ISSUE   = 2'b01,
    PS_CAPTURE = 2'b10,
    PS_BOTH    = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/wave_rom_scheduler_if.sv
// rtl/wave_rom_scheduler_if.sv - voice request, ROM and sample signals bundled with modports
interface wave_rom_scheduler_if
  import note_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
);

  logic [NUM_VOICES-1:0]        req;
  logic [NUM_VOICES*ADDR_W-1:0] voice_addr;
  logic [NUM_VOICES-1:0]        voice_en;
  logic [NUM_VOICES-1:0]        ack;
  logic [ADDR_W-1:0]            rom_addr;
  logic                         rom_en;
  logic [DATA_W-1:0]            rom_data;
  logic [NUM_VOICES*DATA_W-1:0] samples;
  logic [NUM_VOICES-1:0]        sample_valid;
  logic                         busy;

  modport slave (
    input  req, voice_addr, voice_en, rom_data,
    output ack, rom_addr, rom_en, samples, sample_valid, busy
  );

  modport master (
    output req, voice_addr, voice_en, rom_data,
    input  ack, rom_addr, rom_en, samples, sample_valid, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of one requester, searching upward from a pointer
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);

  int   w_cand;
  logic w_found;

  // Walk candidates ptr, ptr+1, ... wrapping at N; first requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_idx            = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wave_rom_scheduler.sv
// rtl/wave_rom_scheduler.sv - shares one synchronous waveform ROM among voices; option WAVE_SCHED_SILENCE_EN
module wave_rom_scheduler
  import note_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  wave_rom_scheduler_if.slave  bus
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  pipe_state_e             r_state;
  pipe_state_e             w_state_next;
  logic                    w_in_issue;
  logic                    w_in_capture;
  logic                    w_cap_next;
  logic                    w_cap_ok;

  logic [NUM_VOICES-1:0]   r_pending;
  logic [ADDR_W-1:0]       r_addr [NUM_VOICES];
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_issue_idx;
  logic [IDX_W-1:0]        r_cap_idx;
  logic [NUM_VOICES-1:0]   r_ack;
  logic [ADDR_W-1:0]       r_rom_addr;
  logic [DATA_W-1:0]       r_samples [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_sample_valid;

  logic [NUM_VOICES-1:0]   w_grant;
  logic [IDX_W-1:0]        w_grant_idx;
  logic                    w_any;

  rr_arbiter #(.N(NUM_VOICES), .IDX_W(IDX_W)) u_arb (
    .i_req   (r_pending),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  assign w_any        = |w_grant;
  assign w_in_issue   = (r_state == PS_ISSUE)   || (r_state == PS_BOTH);
  assign w_in_capture = (r_state == PS_CAPTURE) || (r_state == PS_BOTH);

`ifdef WAVE_SCHED_SILENCE_EN
  // A voice disabled while its read is in flight loses that read.
  assign w_cap_next = w_in_issue && bus.voice_en[r_issue_idx];
  assign w_cap_ok   = w_in_capture && bus.voice_en[r_cap_idx];
`else
  assign w_cap_next = w_in_issue;
  assign w_cap_ok   = w_in_capture;
`endif

  // Pipeline occupancy register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= PS_IDLE;
    else       r_state <= w_state_next;
  end

  // Issue stage fills whenever a grant is made; capture follows issue.
  always_comb begin
    w_state_next = PS_IDLE;
    case ({w_cap_next, w_any})
      2'b01:   w_state_next = PS_ISSUE;
      2'b10:   w_state_next = PS_CAPTURE;
      2'b11:   w_state_next = PS_BOTH;
      default: w_state_next = PS_IDLE;
    endcase
  end

  // Request capture, grant issue and sample write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending      <= '0;
      r_ptr          <= '0;
      r_issue_idx    <= '0;
      r_cap_idx      <= '0;
      r_ack          <= '0;
      r_rom_addr     <= '0;
      r_sample_valid <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_addr[i]    <= '0;
        r_samples[i] <= MID;
      end
    end else begin
      // A fresh request wins over the grant clear, so it is never lost.
      r_pending <= bus.voice_en & ((r_pending & ~w_grant) | bus.req);
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (bus.req[i] && bus.voice_en[i]) r_addr[i] <= bus.voice_addr[i*ADDR_W +: ADDR_W];
      end

      r_ack <= w_grant;
      if (w_any) begin
        r_rom_addr  <= r_addr[w_grant_idx];
        r_issue_idx <= w_grant_idx;
        r_ptr       <= (w_grant_idx == IDX_W'(NUM_VOICES-1)) ? '0 : w_grant_idx + IDX_W'(1);
      end
      r_cap_idx <= r_issue_idx;

      r_sample_valid <= '0;
      if (w_cap_ok) begin
        r_samples[r_cap_idx]      <= bus.rom_data;
        r_sample_valid[r_cap_idx] <= 1'b1;
      end
`ifdef WAVE_SCHED_SILENCE_EN
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (!bus.voice_en[i]) r_samples[i] <= MID;
      end
`endif
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_pack
    assign bus.samples[gi*DATA_W +: DATA_W] = r_samples[gi];
  end

  assign bus.ack          = r_ack;
  assign bus.rom_en       = w_in_issue;
  assign bus.rom_addr     = r_rom_addr;
  assign bus.sample_valid = r_sample_valid;
  assign bus.busy         = (|r_pending) | w_in_issue | w_in_capture;

endmodule
